// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: width codes, FSM state encoding,
// owner codes and the address range check.
package ram_arbiter_pkg;

   // RAM access width codes, as presented on d_width / ram_width
   localparam logic [1:0] RAM_WIDTH64 = 2'd0;
   localparam logic [1:0] RAM_WIDTH32 = 2'd1;
   localparam logic [1:0] RAM_WIDTH16 = 2'd2;
   localparam logic [1:0] RAM_WIDTH8  = 2'd3;

   // Arbiter FSM state encoding
   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_ISSUE   = 2'd1;
   localparam logic [1:0] ARB_CAPTURE = 2'd2;
   localparam logic [1:0] ARB_DONE    = 2'd3;

   // Current owner of the RAM
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_I    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;

   // An access faults when its word index, or the word after it that the
   // RAM also reads, lies past the last RAM word.
   function automatic logic addr_fault(input logic [60:0] word_idx,
                                       input logic [60:0] last_ok_word);
      return word_idx > last_ok_word;
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer selects the tie winner
// (0 = data port, 1 = fetch port) and flips to the loser on each accept.
module rr_arb2 #(
   parameter bit RESET_PTR = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_d,
   input  logic req_i,
   input  logic accept,
   output logic gnt_d,
   output logic gnt_i
);

   logic rr_ptr;

   // Grant the sole requester, or the pointer's choice on a tie
   always_comb begin
      gnt_d = req_d & (~req_i | ~rr_ptr);
      gnt_i = req_i & (~req_d |  rr_ptr);
   end

   // After every accepted grant, favour the other port next time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= RESET_PTR;
      end else if (accept) begin
         if (gnt_d)
            rr_ptr <= 1'b1;
         else if (gnt_i)
            rr_ptr <= 1'b0;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port registered-read RAM between the instruction fetch
// port and the data load/store port. One access in flight at a time:
// IDLE -> ISSUE (ram_cs) -> CAPTURE (read data valid) -> DONE (ack).
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned RAM_BYTES = 65536,
   parameter int unsigned RESET_PTR = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [63:0] i_addr,
   output logic        i_ack,
   output logic        i_err,
   output logic [63:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   input  logic [1:0]  d_width,
   output logic        d_ack,
   output logic        d_err,
   output logic [63:0] d_rdata,
   output logic        ram_cs,
   output logic        ram_we,
   output logic [63:0] ram_addr,
   output logic [63:0] ram_wdata,
   output logic [1:0]  ram_width,
   input  logic [63:0] ram_rdata
);

   // Highest word index whose successor word still exists in the RAM
   localparam logic [60:0] LAST_OK_WORD = 61'(RAM_BYTES / 8 - 2);

   logic [1:0]  state;
   logic [1:0]  owner;
   logic        err_q;
   logic        op_we;

   logic        accept;
   logic        gnt_d;
   logic        gnt_i;
   logic [63:0] gnt_addr;
   logic        gnt_fault;

   rr_arb2 #(
      .RESET_PTR (RESET_PTR != 0)
   ) u_rr (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_d  (d_req),
      .req_i  (i_req),
      .accept (accept),
      .gnt_d  (gnt_d),
      .gnt_i  (gnt_i)
   );

   // Grant decode and range check for the request being accepted in IDLE
   always_comb begin
      accept    = (state == ARB_IDLE) & (i_req | d_req);
      gnt_addr  = gnt_d ? d_addr : i_addr;
      gnt_fault = addr_fault(gnt_addr[63:3], LAST_OK_WORD);
   end

   // Access sequencer: latch the granted request and step through the RAM timing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         owner     <= OWN_NONE;
         err_q     <= 1'b0;
         op_we     <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_width <= RAM_WIDTH64;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (accept) begin
                  owner <= gnt_d ? OWN_D : OWN_I;
                  if (gnt_fault) begin
                     err_q <= 1'b1;
                     op_we <= 1'b0;
                     state <= ARB_DONE;
                  end else begin
                     err_q     <= 1'b0;
                     op_we     <= gnt_d & d_we;
                     ram_addr  <= gnt_addr;
                     ram_wdata <= gnt_d ? d_wdata : '0;
                     ram_width <= gnt_d ? d_width : RAM_WIDTH64;
                     state     <= ARB_ISSUE;
                  end
               end
            end
            ARB_ISSUE: begin
               state <= ARB_CAPTURE;
            end
            ARB_CAPTURE: begin
               state <= ARB_DONE;
            end
            default: begin
               owner <= OWN_NONE;
               err_q <= 1'b0;
               op_we <= 1'b0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Read-data holding registers, loaded only at the end of a read's CAPTURE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rdata <= '0;
         d_rdata <= '0;
      end else if (state == ARB_CAPTURE && !op_we) begin
         if (owner == OWN_I)
            i_rdata <= ram_rdata;
         else if (owner == OWN_D)
            d_rdata <= ram_rdata;
      end
   end

   // RAM strobes and per-port completion decoded from the FSM state
   always_comb begin
      ram_cs = (state == ARB_ISSUE);
      ram_we = ram_cs & op_we;
      i_ack  = (state == ARB_DONE) & (owner == OWN_I);
      d_ack  = (state == ARB_DONE) & (owner == OWN_D);
      i_err  = i_ack & err_q;
      d_err  = d_ack & err_q;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 64-byte behavioural RAM.
module tb_ram_arbiter;

   localparam logic [63:0] W2 = 64'h1122334455667788;
   localparam logic [63:0] W4 = 64'h0102030405060708;
   localparam logic [63:0] W6 = 64'hCAFEF00DDEADBEEF;

   logic        clk;
   logic        rst_n;
   logic        i_req;
   logic [63:0] i_addr;
   logic        i_ack;
   logic        i_err;
   logic [63:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [1:0]  d_width;
   logic        d_ack;
   logic        d_err;
   logic [63:0] d_rdata;
   logic        ram_cs;
   logic        ram_we;
   logic [63:0] ram_addr;
   logic [63:0] ram_wdata;
   logic [1:0]  ram_width;
   logic [63:0] ram_rdata;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   ram_arbiter #(
      .RAM_BYTES (64),
      .RESET_PTR (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_err     (i_err),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_width   (d_width),
      .d_ack     (d_ack),
      .d_err     (d_err),
      .d_rdata   (d_rdata),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_width (ram_width),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: byte array, registered 8-byte little-endian read
   logic [7:0] mem [64];
   logic       preload;

   function automatic logic [7:0] init_byte(input int unsigned k);
      logic [63:0] w;
      case (k / 8)
         2:       w = W2;
         4:       w = W4;
         6:       w = W6;
         default: w = {8{8'(k)}};
      endcase
      return 8'(w >> (8 * (k % 8)));
   endfunction

   function automatic logic [63:0] rd_word(input logic [5:0] a);
      logic [63:0] r;
      for (int k = 0; k < 8; k++)
         r[8*k +: 8] = mem[6'(a + 6'(k))];
      return r;
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < 64; k++)
            mem[k] <= init_byte(k);
      end else if (ram_cs) begin
         if (ram_we) begin
            for (int k = 0; k < 8; k++)
               if (k < (8 >> ram_width))
                  mem[6'(ram_addr[5:0] + 6'(k))] <= ram_wdata[8*k +: 8];
         end else begin
            ram_rdata <= rd_word(ram_addr[5:0]);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One access from cycle 0 (request driven just after a rising edge);
   // request dropped when its ack is seen; 12 cycles observed.
   task automatic do_access(input logic use_d, input logic we, input logic [63:0] addr,
                            input logic [63:0] wdata, input logic [1:0] width,
                            output int ack_cyc, output logic err_seen,
                            output logic [15:0] cs_mask, output logic [15:0] we_mask,
                            output logic other_ack);
      @(posedge clk);
      #1;
      if (use_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_width = width;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      ack_cyc   = -1;
      err_seen  = 1'b0;
      cs_mask   = '0;
      we_mask   = '0;
      other_ack = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         cs_mask[c] = ram_cs;
         we_mask[c] = ram_we;
         other_ack  = other_ack | (use_d ? i_ack : d_ack);
         if ((use_d ? d_ack : i_ack) && ack_cyc < 0) begin
            ack_cyc  = c;
            err_seen = use_d ? d_err : i_err;
            d_req    = 1'b0;
            i_req    = 1'b0;
         end
      end
   endtask

   int          ack_cyc;
   logic        err_seen;
   logic        other_ack;
   logic [15:0] cs_mask;
   logic [15:0] we_mask;
   logic [15:0] iack_mask;
   logic [15:0] dack_mask;
   logic        both;
   logic        any_dack;
   logic [63:0] d_prev;
   logic [63:0] i_prev;

   initial begin
      preload = 1'b1;
      rst_n   = 1'b0;
      i_req   = 1'b0; i_addr = '0;
      d_req   = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_width = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      preload = 1'b0;
      rst_n   = 1'b1;
      @(negedge clk);
      check("rst_cs",      64'(ram_cs),   64'd0);
      check("rst_we",      64'(ram_we),   64'd0);
      check("rst_acks",    64'({i_ack, d_ack, i_err, d_err}), 64'd0);
      check("rst_addr",    ram_addr,      64'd0);
      check("rst_rdata",   i_rdata | d_rdata, 64'd0);

      // Contention from reset pointer 0: grants D, I, D, I
      @(posedge clk);
      #1;
      i_req = 1'b1; i_addr = 64'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h30; d_width = 2'd0;
      iack_mask = '0; dack_mask = '0; cs_mask = '0; both = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         cs_mask[c]   = ram_cs;
         iack_mask[c] = i_ack;
         dack_mask[c] = d_ack;
         both         = both | (i_ack & d_ack);
      end
      i_req = 1'b0; d_req = 1'b0;
      check("cont_dack", 64'(dack_mask), 64'h0808);
      check("cont_iack", 64'(iack_mask), 64'h8080);
      check("cont_cs",   64'(cs_mask),   64'h2222);
      check("cont_both", 64'(both),      64'd0);
      check("cont_rd_i", i_rdata,        W2);
      check("cont_rd_d", d_rdata,        W6);
      repeat (2) @(posedge clk);

      // Fetch alone at 0x10
      do_access(1'b0, 1'b0, 64'h10, '0, 2'd0, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("fetch_ack",   64'(ack_cyc),  64'd3);
      check("fetch_err",   64'(err_seen), 64'd0);
      check("fetch_cs",    64'(cs_mask),  64'h0002);
      check("fetch_data",  i_rdata,       W2);
      check("fetch_other", 64'(other_ack), 64'd0);

      // Byte store to 0x21
      do_access(1'b1, 1'b1, 64'h21, 64'hAB, 2'd3, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("st_ack",  64'(ack_cyc),  64'd3);
      check("st_err",  64'(err_seen), 64'd0);
      check("st_cs",   64'(cs_mask),  64'h0002);
      check("st_we",   64'(we_mask),  64'h0002);
      check("st_keep", d_rdata,       W6);

      // 64-bit load from 0x20 sees the stored byte in lane 1
      do_access(1'b1, 1'b0, 64'h20, '0, 2'd0, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("ld_ack",  64'(ack_cyc), 64'd3);
      check("ld_we",   64'(we_mask), 64'h0000);
      check("ld_data", d_rdata,      64'h010203040506AB08);

      // Data access at 0x38 reads past the end: fault
      d_prev = d_rdata;
      do_access(1'b1, 1'b0, 64'h38, '0, 2'd0, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("dflt_ack",  64'(ack_cyc),  64'd1);
      check("dflt_err",  64'(err_seen), 64'd1);
      check("dflt_cs",   64'(cs_mask),  64'h0000);
      check("dflt_keep", d_rdata,       d_prev);

      // Last legal word 0x30
      do_access(1'b1, 1'b0, 64'h30, '0, 2'd0, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("dok_ack",  64'(ack_cyc),  64'd3);
      check("dok_err",  64'(err_seen), 64'd0);
      check("dok_data", d_rdata,       W6);

      // Fetch fault at 0x3C
      i_prev = i_rdata;
      do_access(1'b0, 1'b0, 64'h3C, '0, 2'd0, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("iflt_ack",  64'(ack_cyc),  64'd1);
      check("iflt_err",  64'(err_seen), 64'd1);
      check("iflt_cs",   64'(cs_mask),  64'h0000);
      check("iflt_keep", i_rdata,       i_prev);

      // Reset asserted during CAPTURE of a load
      @(posedge clk);
      #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 64'h28; d_width = 2'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      d_req = 1'b0;
      @(negedge clk);
      check("mrst_cs",    64'(ram_cs),  64'd0);
      check("mrst_ack",   64'({i_ack, d_ack}), 64'd0);
      check("mrst_addr",  ram_addr,     64'd0);
      check("mrst_rdata", i_rdata | d_rdata, 64'd0);
      any_dack = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) rst_n = 1'b1;
         @(negedge clk);
         any_dack = any_dack | d_ack;
      end
      check("mrst_noack", 64'(any_dack), 64'd0);

      do_access(1'b0, 1'b0, 64'h10, '0, 2'd0, ack_cyc, err_seen, cs_mask, we_mask, other_ack);
      check("post_ack",  64'(ack_cyc), 64'd3);
      check("post_data", i_rdata,      W2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port test RAM between the instruction-fetch port (read-only, 64-bit) and the data load/store port.
- Sequences each access against the RAM's registered-read timing: address and control in cycle T, `data_out` valid in T+1.
- Returns read data in a holding register and acknowledges with a one-cycle pulse.
- Range-checks addresses and faults accesses that would index past the end of the RAM, including the RAM's second (word+1) read.

Parameters:
- RAM_BYTES, 65536, size of the attached RAM in bytes; must be a multiple of 8 and at least 16.
- RESET_PTR, 0, initial round-robin pointer: 0 = data port wins the first tie, 1 = fetch port wins.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; hold with i_addr stable until i_ack
- i_addr  in  64  fetch byte address
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch fault flag, valid with i_ack
- i_rdata  out  64  fetched data, held until next fetch completes
- d_req  in  1  data request; hold with d_we, d_addr, d_wdata, d_width stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  64  data byte address
- d_wdata  in  64  store data, right-justified
- d_width  in  2  width code: 0 = 64-bit, 1 = 32-bit, 2 = 16-bit, 3 = 8-bit
- d_ack  out  1  one-cycle data completion pulse, for loads and stores
- d_err  out  1  data fault flag, valid with d_ack
- d_rdata  out  64  load data, held until next load completes
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_addr  out  64  RAM byte address
- ram_wdata  out  64  RAM write data
- ram_width  out  2  RAM write width code
- ram_rdata  in  64  RAM read data, valid the cycle after ram_cs

Behaviour:
- Reset values:
  - state = IDLE, owner = none, rr_ptr = RESET_PTR.
  - All acks and errs 0, ram_cs 0, ram_we 0.
  - ram_addr, ram_wdata, ram_width, i_rdata, d_rdata all 0.
- States:
  - IDLE: sample requests and grant.
    - No request: stay in IDLE.
    - Granted and address in range: go to ISSUE.
    - Granted and faulting: go to DONE with err set.
  - ISSUE (one cycle): ram_cs = 1; ram_we = d_we only when the owner is the data port. ram_addr, ram_wdata and ram_width are driven from the owner's inputs; for fetch, width = 0 and we = 0. Stores commit at the ISSUE edge. Next state: CAPTURE.
  - CAPTURE (one cycle): ram_cs = 0; ram_addr held. For reads, ram_rdata is loaded into the owner's rdata register at the closing edge. Next state: DONE.
  - DONE (one cycle): owner's ack = 1, err as latched. Next state: IDLE.
- Latency:
  - Normal access: request seen in IDLE at cycle 0, ack in cycle 3.
  - Faulting access: ack in cycle 1.
  - The requester may change or drop req from the edge ending DONE, so IDLE samples fresh values and no stale re-grant occurs.
- Arbitration:
  - Only one request: grant it.
  - Both requests: grant the port selected by rr_ptr.
  - On every grant, rr_ptr points to the other port.
- Fault rule:
  - Fault if addr[63:3] > RAM_BYTES/8 − 2.
  - On fault: no ram_cs, rdata register unchanged, err = 1 with ack.
- Width: d_width is passed through unmodified. Byte-lane shifting and unaligned split across two words are handled by the RAM.
- Requester drops req mid-access (protocol violation): the access still completes and ack still pulses.
- Reset mid-operation:
  - Immediate return to IDLE; no ack issued.
  - A store already clocked at the ISSUE edge remains committed.
- ram_cs is never asserted in two consecutive cycles; at most one access is in flight.

Decomposition:
- Shared package/header (io_def.vh):
  - Width codes RAM_WIDTH64/32/16/8.
  - State encoding ARB_IDLE/ISSUE/CAPTURE/DONE.
  - Owner codes OWN_I/OWN_D.
- Sub-module rr_arb2: two-request round-robin grant with pointer update on an accept strobe; about 30 lines.
- The FSM, output muxing and fault check stay in ram_arbiter.

Test Plan:
- Fetch alone: i_req, i_addr = 0x10, RAM word 2 = 0x1122334455667788 → ram_cs only in cycle 1, i_ack in cycle 3, i_rdata = 0x1122334455667788, i_err = 0.
- Store then load: d_we = 1, d_width = 3, d_addr = 0x21, d_wdata = 0xAB → d_ack in cycle 3. Then load 64-bit at 0x20 → byte 1 of result = 0xAB, other bytes unchanged.
- Contention, RESET_PTR = 0: i_req and d_req both high and held, both re-requesting after each ack → grants D, I, D, I. Each ack is 4 cycles after the previous; i_ack and d_ack are never both high.
- Fault, RAM_BYTES = 64: d_addr = 0x38 → d_ack in cycle 1 with d_err = 1, ram_cs never asserted, d_rdata unchanged. d_addr = 0x30 → no fault.
- Reset mid-access: rst_n low during CAPTURE of a load → next cycle all outputs at reset values and no d_ack ever pulses. After release, a new fetch completes normally with 3-cycle latency.
